cbd_sampler_par: RTL and testbench

Parametrised centred-binomial-distribution sampler for the Kyber hash/sampling datapath. It pulls 64-bit pseudo-random words from the Keccak squeeze port and buffers leftover bits across word boundaries. It emits `LANES` coefficients per output beat, with eta selectable per run. It also adds output back-pressure, which the current CBD path lacks. It sits between `keccak` and the write buffer / SRAM.

---
 rtl/cbd_pkg.sv | 19 +
 rtl/cbd_sampler_par_if.sv | 30 +++
 rtl/cbd_lane.sv | 40 ++++
 rtl/cbd_sampler_par.sv | 149 ++++++++++++++
 tb/tb_cbd_sampler_par.sv | 316 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/cbd_pkg.sv
// cbd_pkg: shared FSM type, Kyber constants and bit helpers for the CBD sampler.
package cbd_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } cbd_state_e;

  localparam int KYBER_Q = 3329;
  localparam int BUF_W   = 128;
  localparam int PRG_W   = 64;

  // Number of set bits in a 3-bit field (0..3).
  function automatic logic [1:0] popcnt3(input logic [2:0] v);
    return {1'b0, v[0]} + {1'b0, v[1]} + {1'b0, v[2]};
  endfunction

endpackage

// File: rtl/cbd_sampler_par_if.sv
// cbd_sampler_par_if: PRG word input, coefficient beat output and run control.
// master = producer/consumer side (testbench, keccak + write buffer), slave = sampler.
interface cbd_sampler_par_if #(
  parameter int LANES   = 4,
  parameter int COEFF_W = 12,
  parameter int ADDR_W  = 8
);

  logic                        start;
  logic                        n;
  logic [cbd_pkg::PRG_W-1:0]   In;
  logic                        ready;
  logic                        give_bits;
  logic [LANES*COEFF_W-1:0]    Out;
  logic                        out_valid;
  logic                        out_ready;
  logic [ADDR_W-1:0]           address;
  logic                        done;

  modport master (
    output start, n, In, ready, out_ready,
    input  give_bits, Out, out_valid, address, done
  );

  modport slave (
    input  start, n, In, ready, out_ready,
    output give_bits, Out, out_valid, address, done
  );

endinterface

// File: rtl/cbd_lane.sv
// cbd_lane: one centred-binomial coefficient from a 2*eta-bit slice.
// With CBD_MODQ_EN defined the result is reduced into [0, q-1]; otherwise it
// is sign-extended two's complement.
module cbd_lane
  import cbd_pkg::*;
#(
  parameter int COEFF_W = 12
) (
  input  logic [5:0]         bits,
  input  logic               eta3,
  output logic [COEFF_W-1:0] coeff
);

  logic [1:0] a_s;
  logic [1:0] b_s;
  logic [3:0] d_s;

  // Popcount both halves of the slice and map the difference to the output encoding.
  always_comb begin
    if (eta3) begin
      a_s = popcnt3(bits[2:0]);
      b_s = popcnt3(bits[5:3]);
    end else begin
      a_s = popcnt3({1'b0, bits[1:0]});
      b_s = popcnt3({1'b0, bits[3:2]});
    end
    d_s = {2'b00, a_s} - {2'b00, b_s};
`ifdef CBD_MODQ_EN
    // Negative x becomes q + x; the sign-extended add wraps modulo 2**COEFF_W.
    if (d_s[3]) begin
      coeff = COEFF_W'(KYBER_Q) + {{(COEFF_W-4){1'b1}}, d_s};
    end else begin
      coeff = {{(COEFF_W-4){1'b0}}, d_s};
    end
`else
    coeff = {{(COEFF_W-4){d_s[3]}}, d_s};
`endif
  end

endmodule

// File: rtl/cbd_sampler_par.sv
// cbd_sampler_par: LANES-wide CBD sampler fed by 64-bit PRG words through a
// 128-bit leftover buffer, with output back-pressure.
// Optional build macro CBD_MODQ_EN selects mod-q coefficient output (see cbd_lane).
module cbd_sampler_par
  import cbd_pkg::*;
#(
  parameter int LANES    = 4,
  parameter int COEFF_W  = 12,
  parameter int N_COEFFS = 256,
  parameter int ADDR_W   = 8
) (
  input logic              clk,
  input logic              rst,
  cbd_sampler_par_if.slave bus
);

  localparam int OUT_W   = LANES * COEFF_W;
  localparam int CNT_W   = $clog2(BUF_W + 1);
  localparam int WORDS_W = $clog2(N_COEFFS * 3 / 32 + 1);

  localparam logic [CNT_W-1:0]   G_ETA2     = CNT_W'(LANES * 4);
  localparam logic [CNT_W-1:0]   G_ETA3     = CNT_W'(LANES * 6);
  localparam logic [CNT_W-1:0]   CNT_ROOM   = CNT_W'(BUF_W - PRG_W);
  localparam logic [CNT_W-1:0]   CNT_WORD   = CNT_W'(PRG_W);
  localparam logic [WORDS_W-1:0] WORDS_ETA2 = WORDS_W'(N_COEFFS / 16);
  localparam logic [WORDS_W-1:0] WORDS_ETA3 = WORDS_W'(N_COEFFS * 3 / 32);
  localparam logic [ADDR_W-1:0]  LAST_GRP   = ADDR_W'(N_COEFFS / LANES - 1);

  cbd_state_e         state_r;
  logic               eta_r;
  logic [BUF_W-1:0]   buf_r;
  logic [CNT_W-1:0]   cnt_r;
  logic [WORDS_W-1:0] words_r;
  logic [ADDR_W-1:0]  grp_r;
  logic [OUT_W-1:0]   out_r;
  logic               out_valid_r;
  logic [ADDR_W-1:0]  address_r;
  logic               done_r;

  logic [CNT_W-1:0]   g_s;
  logic [WORDS_W-1:0] words_tot_s;
  logic               beat_acc_s;
  logic               cons_s;
  logic [CNT_W-1:0]   cnt_after_s;
  logic [BUF_W-1:0]   buf_after_s;
  logic               give_s;
  logic               word_acc_s;
  logic [BUF_W-1:0]   buf_next_s;
  logic [CNT_W-1:0]   cnt_next_s;
  logic [OUT_W-1:0]   lanes_s;

  // Lane i reads its 2*eta bits at offset i*2*eta from the bottom of the buffer.
  generate
    for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
      logic [5:0] slice_s;
      assign slice_s = eta_r ? buf_r[gi*6 +: 6] : {2'b00, buf_r[gi*4 +: 4]};
      cbd_lane #(.COEFF_W(COEFF_W)) u_lane (
        .bits  (slice_s),
        .eta3  (eta_r),
        .coeff (lanes_s[gi*COEFF_W +: COEFF_W])
      );
    end
  endgenerate

  // Group consumption, PRG word request and next buffer contents for this cycle.
  always_comb begin
    g_s         = eta_r ? G_ETA3 : G_ETA2;
    words_tot_s = eta_r ? WORDS_ETA3 : WORDS_ETA2;
    beat_acc_s  = out_valid_r && bus.out_ready;
    cons_s      = (state_r == RUN) && (cnt_r >= g_s) && (!out_valid_r || bus.out_ready);
    cnt_after_s = cons_s ? (cnt_r - g_s) : cnt_r;
    buf_after_s = cons_s ? (buf_r >> g_s) : buf_r;
    // Room is judged after this cycle's consumption so a full word always fits.
    give_s      = (state_r == RUN) && (cnt_after_s <= CNT_ROOM) && (words_r < words_tot_s);
    word_acc_s  = give_s && bus.ready;
    if (word_acc_s) begin
      buf_next_s = buf_after_s | ({{(BUF_W-PRG_W){1'b0}}, bus.In} << cnt_after_s);
      cnt_next_s = cnt_after_s + CNT_WORD;
    end else begin
      buf_next_s = buf_after_s;
      cnt_next_s = cnt_after_s;
    end
  end

  // Run FSM with bit buffer, counters and the held output beat.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r     <= IDLE;
      eta_r       <= 1'b0;
      buf_r       <= '0;
      cnt_r       <= '0;
      words_r     <= '0;
      grp_r       <= '0;
      out_r       <= '0;
      out_valid_r <= 1'b0;
      address_r   <= '0;
      done_r      <= 1'b0;
    end else begin
      done_r <= 1'b0;
      case (state_r)
        IDLE: begin
          if (bus.start) begin
            state_r     <= RUN;
            eta_r       <= bus.n;
            buf_r       <= '0;
            cnt_r       <= '0;
            words_r     <= '0;
            grp_r       <= '0;
            address_r   <= '0;
            out_valid_r <= 1'b0;
          end
        end
        RUN: begin
          buf_r <= buf_next_s;
          cnt_r <= cnt_next_s;
          if (word_acc_s) begin
            words_r <= words_r + WORDS_W'(1);
          end
          // The register refills on the same edge its current beat is accepted.
          if (cons_s) begin
            out_r       <= lanes_s;
            address_r   <= grp_r;
            grp_r       <= grp_r + ADDR_W'(1);
            out_valid_r <= 1'b1;
          end else if (beat_acc_s) begin
            out_valid_r <= 1'b0;
          end
          if (beat_acc_s && (address_r == LAST_GRP)) begin
            state_r <= DONE;
            done_r  <= 1'b1;
          end
        end
        DONE: begin
          state_r <= IDLE;
        end
        default: begin
          state_r <= IDLE;
        end
      endcase
    end
  end

  assign bus.give_bits = give_s;
  assign bus.Out       = out_r;
  assign bus.out_valid = out_valid_r;
  assign bus.address   = address_r;
  assign bus.done      = done_r;

endmodule

// File: tb/tb_cbd_sampler_par.sv
// tb_cbd_sampler_par: directed bench for cbd_sampler_par with a bit-stream
// reference model for coefficient values. Honours CBD_MODQ_EN for encodings.
module tb_cbd_sampler_par;

  localparam int LANES    = 4;
  localparam int COEFF_W  = 12;
  localparam int N_COEFFS = 256;
  localparam int ADDR_W   = 8;
  localparam int NBEATS   = N_COEFFS / LANES;
  localparam int OUT_W    = LANES * COEFF_W;
`ifdef CBD_MODQ_EN
  localparam logic [COEFF_W-1:0] NEG2 = 12'd3327;
`else
  localparam logic [COEFF_W-1:0] NEG2 = 12'hFFE;
`endif

  logic clk;
  logic rst;
  int   checks;
  int   errors;

  logic [63:0]       words    [24];
  logic [OUT_W-1:0]  got_out  [NBEATS];
  logic [ADDR_W-1:0] got_addr [NBEATS];
  int nbeats;
  int nwords;
  int ndone;
  int give_late;
  int stall_cycles;
  int bp_unstable;
  bit bp_give_low;

  cbd_sampler_par_if #(.LANES(LANES), .COEFF_W(COEFF_W), .ADDR_W(ADDR_W)) bus ();

  cbd_sampler_par #(
    .LANES(LANES), .COEFF_W(COEFF_W), .N_COEFFS(N_COEFFS), .ADDR_W(ADDR_W)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [COEFF_W-1:0] enc(input int x);
    int v;
`ifdef CBD_MODQ_EN
    v = (x < 0) ? 3329 + x : x;
`else
    v = (x < 0) ? (1 << COEFF_W) + x : x;
`endif
    return v[COEFF_W-1:0];
  endfunction

  // Coefficient k of the run from the LSB-first concatenation of the words.
  function automatic int ref_coeff(input int eta, input int k);
    int a;
    int b;
    int p;
    a = 0;
    b = 0;
    for (int j = 0; j < eta; j++) begin
      p = k * 2 * eta + j;
      if (words[p / 64][p % 64]) a++;
      p = k * 2 * eta + eta + j;
      if (words[p / 64][p % 64]) b++;
    end
    return a - b;
  endfunction

  function automatic logic [OUT_W-1:0] ref_beat(input int eta, input int j);
    logic [OUT_W-1:0] r;
    r = '0;
    for (int i = 0; i < LANES; i++) r[i*COEFF_W +: COEFF_W] = enc(ref_coeff(eta, j * LANES + i));
    return r;
  endfunction

  task automatic fill_random();
    for (int i = 0; i < 24; i++) words[i] = {$urandom, $urandom};
  endtask

  // Start a run and drive/observe it cycle by cycle; inputs change at negedge,
  // outputs are sampled 1 time unit later.
  task automatic run(input bit eta3, input int start_at, input int bp_from,
                     input int bp_len, input int max_cyc);
    int total;
    int post;
    bit holding;
    logic give;
    logic ov;
    logic [OUT_W-1:0] hold_out;
    logic [ADDR_W-1:0] hold_addr;
    total = eta3 ? 24 : 16;
    nbeats = 0; nwords = 0; ndone = 0; give_late = 0;
    stall_cycles = 0; bp_unstable = 0; bp_give_low = 1'b0;
    post = 0; holding = 1'b0; hold_out = '0; hold_addr = '0;
    for (int j = 0; j < NBEATS; j++) begin
      got_out[j]  = 'x;
      got_addr[j] = 'x;
    end
    for (int cyc = 0; cyc < max_cyc && post < 4; cyc++) begin
      bus.start     = (cyc == 0) || (cyc == start_at);
      bus.n         = (cyc == 0) ? eta3 : ~eta3;
      bus.In        = words[nwords % 24];
      bus.ready     = 1'b1;
      bus.out_ready = !(cyc >= bp_from && cyc < bp_from + bp_len);
      #1;
      give = bus.give_bits;
      ov   = bus.out_valid;
      if (bus.done) ndone++;
      if (ndone > 0) post++;
      if (give && nwords >= total) give_late++;
      if (!bus.out_ready && !give) bp_give_low = 1'b1;
      if (ov && !bus.out_ready) stall_cycles++;
      if (ov && holding && (bus.Out !== hold_out || bus.address !== hold_addr)) bp_unstable++;
      holding   = ov && !bus.out_ready;
      hold_out  = bus.Out;
      hold_addr = bus.address;
      if (ov && bus.out_ready) begin
        if (nbeats < NBEATS) begin
          got_out[nbeats]  = bus.Out;
          got_addr[nbeats] = bus.address;
        end
        nbeats++;
      end
      if (give && bus.ready) nwords++;
      @(negedge clk);
    end
    bus.start = 1'b0;
    bus.ready = 1'b0;
    bus.out_ready = 1'b1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.start = 1'b0; bus.n = 1'b0; bus.In = '0; bus.ready = 1'b1; bus.out_ready = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    checks++;
    if ({bus.give_bits, bus.out_valid, bus.done, bus.address, bus.Out} !== '0) begin
      errors++;
      $display("FAIL reset_state: got %h expected 0",
               {bus.give_bits, bus.out_valid, bus.done, bus.address, bus.Out});
    end
    @(negedge clk);
    rst = 1'b0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      #1;
      checks++;
      if ({bus.give_bits, bus.out_valid, bus.done, bus.address, bus.Out} !== '0) begin
        errors++;
        $display("FAIL idle_cycle%0d: got %h expected 0", c,
                 {bus.give_bits, bus.out_valid, bus.done, bus.address, bus.Out});
      end
    end
    @(negedge clk);
  endtask

  task automatic test_eta2_vectors();
    fill_random();
    words[0] = 64'h0000_0000_0000_00F3;
    words[1] = 64'hFFFF_FFFF_FFFF_FFFF;
    words[2] = 64'hCCCC_CCCC_CCCC_CCCC;
    run(1'b0, -1, -1, 0, 400);
    checks++;
    if (got_out[0] !== {12'd0, 12'd0, 12'd0, 12'd2}) begin
      errors++; $display("FAIL eta2_lane0_plus2: got %h expected %h", got_out[0], {12'd0, 12'd0, 12'd0, 12'd2});
    end
    checks++;
    if (got_out[4] !== {OUT_W{1'b0}}) begin
      errors++; $display("FAIL eta2_all_ones: got %h expected 0", got_out[4]);
    end
    checks++;
    if (got_out[8] !== {NEG2, NEG2, NEG2, NEG2}) begin
      errors++; $display("FAIL eta2_minus2: got %h expected %h", got_out[8], {NEG2, NEG2, NEG2, NEG2});
    end
    checks++;
    if (nwords != 16 || nbeats != NBEATS || ndone != 1) begin
      errors++; $display("FAIL eta2_counts: got words=%0d beats=%0d done=%0d expected 16/64/1", nwords, nbeats, ndone);
    end
    for (int j = 0; j < NBEATS; j++) begin
      checks++;
      if (got_out[j] !== ref_beat(2, j) || got_addr[j] !== ADDR_W'(j)) begin
        errors++; $display("FAIL eta2_beat%0d: got %h@%0d expected %h@%0d", j, got_out[j], got_addr[j], ref_beat(2, j), j);
      end
    end
  endtask

  task automatic test_eta3_full();
    fill_random();
    run(1'b1, -1, -1, 0, 400);
    checks++;
    if (nwords != 24 || nbeats != NBEATS || ndone != 1 || give_late != 0) begin
      errors++;
      $display("FAIL eta3_counts: got words=%0d beats=%0d done=%0d late_give=%0d expected 24/64/1/0",
               nwords, nbeats, ndone, give_late);
    end
    for (int j = 0; j < NBEATS; j++) begin
      checks++;
      if (got_out[j] !== ref_beat(3, j) || got_addr[j] !== ADDR_W'(j)) begin
        errors++; $display("FAIL eta3_beat%0d: got %h@%0d expected %h@%0d", j, got_out[j], got_addr[j], ref_beat(3, j), j);
      end
    end
  endtask

  task automatic test_straddle();
    fill_random();
    words[0][63:48] = 16'hF000;
    words[1][7:0]   = 8'hC1;
    run(1'b1, -1, -1, 0, 400);
    checks++;
    if (got_out[2] !== {NEG2, 12'd1, 12'd0, 12'd0}) begin
      errors++; $display("FAIL straddle_hand: got %h expected %h", got_out[2], {NEG2, 12'd1, 12'd0, 12'd0});
    end
    for (int j = 0; j < 4; j++) begin
      checks++;
      if (got_out[j] !== ref_beat(3, j)) begin
        errors++; $display("FAIL straddle_beat%0d: got %h expected %h", j, got_out[j], ref_beat(3, j));
      end
    end
  endtask

  task automatic test_back_pressure();
    fill_random();
    run(1'b1, -1, 20, 10, 400);
    checks++;
    if (stall_cycles != 10 || bp_unstable != 0 || !bp_give_low) begin
      errors++;
      $display("FAIL bp_hold: got stalls=%0d unstable=%0d give_dropped=%0d expected 10/0/1",
               stall_cycles, bp_unstable, bp_give_low);
    end
    checks++;
    if (nbeats != NBEATS || ndone != 1) begin
      errors++; $display("FAIL bp_counts: got beats=%0d done=%0d expected 64/1", nbeats, ndone);
    end
    for (int j = 0; j < NBEATS; j++) begin
      checks++;
      if (got_out[j] !== ref_beat(3, j) || got_addr[j] !== ADDR_W'(j)) begin
        errors++; $display("FAIL bp_beat%0d: got %h@%0d expected %h@%0d", j, got_out[j], got_addr[j], ref_beat(3, j), j);
      end
    end
  endtask

  task automatic test_abort();
    bit done_seen;
    fill_random();
    run(1'b1, -1, -1, 0, 30);
    checks++;
    if (ndone != 0 || nbeats == 0) begin
      errors++; $display("FAIL abort_partial: got done=%0d beats=%0d expected 0/>0", ndone, nbeats);
    end
    #2 rst = 1'b1;
    #1;
    checks++;
    if ({bus.give_bits, bus.out_valid, bus.done, bus.address, bus.Out} !== '0) begin
      errors++;
      $display("FAIL abort_clear: got %h expected 0", {bus.give_bits, bus.out_valid, bus.done, bus.address, bus.Out});
    end
    done_seen = 1'b0;
    repeat (5) begin
      @(negedge clk);
      #1;
      if (bus.done) done_seen = 1'b1;
    end
    checks++;
    if (done_seen) begin
      errors++; $display("FAIL abort_no_done: got done=1 expected 0");
    end
    @(negedge clk);
    rst = 1'b0;
    fill_random();
    run(1'b1, -1, -1, 0, 400);
    checks++;
    if (nbeats != NBEATS || ndone != 1 || nwords != 24) begin
      errors++; $display("FAIL abort_rerun: got beats=%0d done=%0d words=%0d expected 64/1/24", nbeats, ndone, nwords);
    end
    for (int j = 0; j < NBEATS; j++) begin
      checks++;
      if (got_out[j] !== ref_beat(3, j) || got_addr[j] !== ADDR_W'(j)) begin
        errors++; $display("FAIL rerun_beat%0d: got %h@%0d expected %h@%0d", j, got_out[j], got_addr[j], ref_beat(3, j), j);
      end
    end
  endtask

  task automatic test_start_ignored();
    fill_random();
    run(1'b1, 15, -1, 0, 400);
    checks++;
    if (nbeats != NBEATS || ndone != 1 || nwords != 24) begin
      errors++; $display("FAIL start_ignored: got beats=%0d done=%0d words=%0d expected 64/1/24", nbeats, ndone, nwords);
    end
    for (int j = 0; j < NBEATS; j++) begin
      checks++;
      if (got_out[j] !== ref_beat(3, j) || got_addr[j] !== ADDR_W'(j)) begin
        errors++; $display("FAIL restart_beat%0d: got %h@%0d expected %h@%0d", j, got_out[j], got_addr[j], ref_beat(3, j), j);
      end
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_eta2_vectors();
    test_eta3_full();
    test_straddle();
    test_back_pressure();
    test_abort();
    test_start_ignored();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
